// File: rtl/fifo_flag_checker.sv
// Passive checker for up to CHANNELS FIFOs. It tracks a model occupancy from the
// accepted traffic and flags overflow, underflow and full/empty flag disagreement.
module fifo_flag_checker #(
    parameter int SIZE_LOG2     = 5,
    parameter int CHANNELS      = 1,
    parameter int STRICT        = 0,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int CYC_WIDTH     = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [CHANNELS-1:0]                       p_write_en,
    input  logic [CHANNELS-1:0]                       p_write_full,
    input  logic [CHANNELS-1:0]                       p_read_en,
    input  logic [CHANNELS-1:0]                       p_read_empty,
    input  logic                                      err_clear,
    output logic [CHANNELS*(SIZE_LOG2+1)-1:0]         occupancy,
    output logic [CHANNELS*4-1:0]                     err_sticky,
    output logic [CHANNELS*ERR_CNT_WIDTH-1:0]         err_count,
    output logic                                      err_any,
    output logic                                      first_err_valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] first_err_channel,
    output logic [3:0]                                first_err_code,
    output logic [CYC_WIDTH-1:0]                      first_err_cycle
);

    localparam int OW  = SIZE_LOG2 + 1;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [OW-1:0] DEPTH    = {1'b1, {SIZE_LOG2{1'b0}}};
    localparam logic          STRICT_B = (STRICT != 0);

    logic [CHANNELS-1:0]      wr_acc, rd_acc, at_full, at_empty;
    logic [OW-1:0]            occ_q    [CHANNELS];
    logic [OW-1:0]            occ_d    [CHANNELS];
    logic [3:0]               sticky_q [CHANNELS];
    logic [3:0]               sticky_d [CHANNELS];
    logic [3:0]               fired    [CHANNELS];
    logic [ERR_CNT_WIDTH-1:0] cnt_q    [CHANNELS];
    logic [ERR_CNT_WIDTH-1:0] cnt_d    [CHANNELS];

    logic [CYC_WIDTH-1:0] stamp_q, stamp_d;
    logic                 fv_q, fv_d;
    logic [CHW-1:0]       fch_q, fch_d;
    logic [3:0]           fcode_q, fcode_d;
    logic [CYC_WIDTH-1:0] fcyc_q, fcyc_d;
    logic                 any_q, any_d;
    logic                 found;
    logic [CHW-1:0]       sel_ch;
    logic [3:0]           sel_code;

    assign wr_acc = p_write_en & ~p_write_full;
    assign rd_acc = p_read_en & ~p_read_empty;

    always_comb begin
        any_d    = 1'b0;
        found    = 1'b0;
        sel_ch   = '0;
        sel_code = '0;
        at_full  = '0;
        at_empty = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            at_full[c]  = (occ_q[c] == DEPTH);
            at_empty[c] = (occ_q[c] == '0);

            // Underflow covers both read-only and simultaneous read/write at zero.
            fired[c][0] = (wr_acc[c] & ~rd_acc[c] & at_full[c])
                        | (STRICT_B & p_write_en[c] & p_write_full[c]);
            fired[c][1] = (rd_acc[c] & at_empty[c])
                        | (STRICT_B & p_read_en[c] & p_read_empty[c]);
            fired[c][2] = p_write_full[c] ^ at_full[c];
            fired[c][3] = p_read_empty[c] ^ at_empty[c];

            occ_d[c] = occ_q[c];
            if (wr_acc[c] && !rd_acc[c] && !at_full[c]) begin
                occ_d[c] = occ_q[c] + OW'(1);
            end else if (rd_acc[c] && !wr_acc[c] && !at_empty[c]) begin
                occ_d[c] = occ_q[c] - OW'(1);
            end

            sticky_d[c] = (err_clear ? 4'b0000 : sticky_q[c]) | fired[c];
            any_d       = any_d | (|sticky_d[c]);

            if (err_clear) begin
                cnt_d[c] = ERR_CNT_WIDTH'(|fired[c]);
            end else if ((|fired[c]) && (cnt_q[c] != '1)) begin
                cnt_d[c] = cnt_q[c] + ERR_CNT_WIDTH'(1);
            end else begin
                cnt_d[c] = cnt_q[c];
            end

            if (!found && (|fired[c])) begin
                found    = 1'b1;
                sel_ch   = CHW'(c);
                sel_code = fired[c];
            end
        end

        stamp_d = (stamp_q == '1) ? stamp_q : stamp_q + CYC_WIDTH'(1);

        fv_d    = fv_q & ~err_clear;
        fch_d   = fch_q;
        fcode_d = fcode_q;
        fcyc_d  = fcyc_q;
        if ((!fv_q || err_clear) && found) begin
            fv_d    = 1'b1;
            fch_d   = sel_ch;
            fcode_d = sel_code;
            fcyc_d  = stamp_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                occ_q[c]    <= '0;
                sticky_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            stamp_q <= '0;
            fv_q    <= 1'b0;
            fch_q   <= '0;
            fcode_q <= '0;
            fcyc_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                occ_q[c]    <= occ_d[c];
                sticky_q[c] <= sticky_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            stamp_q <= stamp_d;
            fv_q    <= fv_d;
            fch_q   <= fch_d;
            fcode_q <= fcode_d;
            fcyc_q  <= fcyc_d;
            any_q   <= any_d;
        end
    end

    always_comb begin
        occupancy  = '0;
        err_sticky = '0;
        err_count  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            occupancy[c*OW +: OW]                       = occ_q[c];
            err_sticky[c*4 +: 4]                        = sticky_q[c];
            err_count[c*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = cnt_q[c];
        end
    end

    assign err_any           = any_q;
    assign first_err_valid   = fv_q;
    assign first_err_channel = fch_q;
    assign first_err_code    = fcode_q;
    assign first_err_cycle   = fcyc_q;

endmodule

// File: tb/tb_fifo_flag_checker.sv
// Directed bench for fifo_flag_checker (DEPTH 4, two channels), with a STRICT=1
// twin fed the same stimulus; expected outputs are queued per step and checked after the edge.
module tb_fifo_flag_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] we, wf, re, em;
    logic       clr;

    logic [5:0]  occ,  occ_s;
    logic [7:0]  stk,  stk_s;
    logic [15:0] cnt,  cnt_s;
    logic        any,  any_s;
    logic        fv,   fv_s;
    logic        fch,  fch_s;
    logic [3:0]  fcd,  fcd_s;
    logic [31:0] fcy,  fcy_s;

    always #5 clk = ~clk;

    fifo_flag_checker #(.SIZE_LOG2(2), .CHANNELS(2), .STRICT(0), .ERR_CNT_WIDTH(8), .CYC_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_write_en(we), .p_write_full(wf), .p_read_en(re), .p_read_empty(em),
        .err_clear(clr),
        .occupancy(occ), .err_sticky(stk), .err_count(cnt), .err_any(any),
        .first_err_valid(fv), .first_err_channel(fch), .first_err_code(fcd), .first_err_cycle(fcy)
    );

    fifo_flag_checker #(.SIZE_LOG2(2), .CHANNELS(2), .STRICT(1), .ERR_CNT_WIDTH(8), .CYC_WIDTH(32)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .p_write_en(we), .p_write_full(wf), .p_read_en(re), .p_read_empty(em),
        .err_clear(clr),
        .occupancy(occ_s), .err_sticky(stk_s), .err_count(cnt_s), .err_any(any_s),
        .first_err_valid(fv_s), .first_err_channel(fch_s), .first_err_code(fcd_s), .first_err_cycle(fcy_s)
    );

    localparam int unsigned S_OCC0 = 0, S_OCC1 = 1, S_STK0 = 2, S_STK1 = 3, S_CNT0 = 4,
                            S_CNT1 = 5, S_ANY = 6, S_FV = 7, S_FCH = 8, S_FCD = 9,
                            S_FCY = 10, S_SSTK0 = 11, S_SOCC0 = 12;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] val;
    } exp_t;

    exp_t        sbq[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ncyc   = 0;
    logic [31:0] ecyc;

    function automatic logic [31:0] obs(input int unsigned sel);
        case (sel)
            S_OCC0:  return {29'd0, occ[2:0]};
            S_OCC1:  return {29'd0, occ[5:3]};
            S_STK0:  return {28'd0, stk[3:0]};
            S_STK1:  return {28'd0, stk[7:4]};
            S_CNT0:  return {24'd0, cnt[7:0]};
            S_CNT1:  return {24'd0, cnt[15:8]};
            S_ANY:   return {31'd0, any};
            S_FV:    return {31'd0, fv};
            S_FCH:   return {31'd0, fch};
            S_FCD:   return {28'd0, fcd};
            S_FCY:   return fcy;
            S_SSTK0: return {28'd0, stk_s[3:0]};
            S_SOCC0: return {29'd0, occ_s[2:0]};
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic exp_push(input string tag, input int unsigned sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) ncyc++;
        #1;
        check_all();
    endtask

    task automatic push_all_zero(input string tag);
        exp_push({tag, "_occ0"}, S_OCC0, 0);
        exp_push({tag, "_occ1"}, S_OCC1, 0);
        exp_push({tag, "_stk0"}, S_STK0, 0);
        exp_push({tag, "_stk1"}, S_STK1, 0);
        exp_push({tag, "_cnt0"}, S_CNT0, 0);
        exp_push({tag, "_cnt1"}, S_CNT1, 0);
        exp_push({tag, "_any"},  S_ANY,  0);
        exp_push({tag, "_fv"},   S_FV,   0);
        exp_push({tag, "_fch"},  S_FCH,  0);
        exp_push({tag, "_fcd"},  S_FCD,  0);
        exp_push({tag, "_fcy"},  S_FCY,  0);
        exp_push({tag, "_sstk0"}, S_SSTK0, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; we = 2'b00; wf = 2'b00; re = 2'b00; em = 2'b11; clr = 1'b0;
        #12;
        push_all_zero("reset");
        check_all();
        rst_n = 1'b1;

        // Idle with correct flags: no errors, stamp advances 0..6.
        for (int i = 0; i < 7; i++) begin
            exp_push("idle_any", S_ANY, 0);
            exp_push("idle_occ0", S_OCC0, 0);
            tick();
        end

        // Both channels report not-empty at occupancy 0, stamp 7.
        em = 2'b00;
        exp_push("emis_stk0", S_STK0, 4'b1000);
        exp_push("emis_stk1", S_STK1, 4'b1000);
        exp_push("emis_fv",   S_FV,   1);
        exp_push("emis_fch",  S_FCH,  0);
        exp_push("emis_fcd",  S_FCD,  4'b1000);
        exp_push("emis_fcy",  S_FCY,  7);
        exp_push("emis_cnt1", S_CNT1, 1);
        exp_push("emis_any",  S_ANY,  1);
        tick();

        em = 2'b11; clr = 1'b1;
        exp_push("clr_stk0", S_STK0, 0);
        exp_push("clr_stk1", S_STK1, 0);
        exp_push("clr_cnt0", S_CNT0, 0);
        exp_push("clr_fv",   S_FV,   0);
        exp_push("clr_any",  S_ANY,  0);
        tick();
        clr = 1'b0;

        // Fill ch0 to depth, then drain, flags always consistent.
        for (int i = 0; i < 4; i++) begin
            we = 2'b01; wf[0] = 1'b0; em[0] = (i == 0);
            exp_push("fill_occ0", S_OCC0, 32'(i + 1));
            exp_push("fill_any",  S_ANY,  0);
            tick();
        end
        we = 2'b00;
        for (int i = 0; i < 4; i++) begin
            re = 2'b01; wf[0] = (i == 0); em[0] = 1'b0;
            exp_push("drain_occ0", S_OCC0, 32'(3 - i));
            exp_push("drain_any",  S_ANY,  0);
            tick();
        end
        re = 2'b00; wf = 2'b00; em = 2'b11;
        exp_push("drained_occ0", S_OCC0, 0);
        exp_push("drained_any",  S_ANY,  0);
        tick();

        // Fill ch1, then write at depth while it wrongly claims not-full.
        for (int i = 0; i < 4; i++) begin
            we = 2'b10; wf[1] = 1'b0; em[1] = (i == 0);
            exp_push("fill1_occ1", S_OCC1, 32'(i + 1));
            tick();
        end
        we = 2'b10; wf[1] = 1'b0; em[1] = 1'b0;
        ecyc = ncyc;
        exp_push("ovf_stk1", S_STK1, 4'b0101);
        exp_push("ovf_occ1", S_OCC1, 4);
        exp_push("ovf_cnt1", S_CNT1, 1);
        exp_push("ovf_fch",  S_FCH,  1);
        exp_push("ovf_fcd",  S_FCD,  4'b0101);
        exp_push("ovf_fcy",  S_FCY,  ecyc);
        exp_push("ovf_stk0", S_STK0, 0);
        exp_push("ovf_any",  S_ANY,  1);
        tick();
        exp_push("ovf2_cnt1", S_CNT1, 2);
        exp_push("ovf2_occ1", S_OCC1, 4);
        exp_push("ovf2_fcy",  S_FCY,  ecyc);
        tick();
        we = 2'b00; wf[1] = 1'b1;

        // Error on ch0 in the same cycle as err_clear wins.
        clr = 1'b1; wf[0] = 1'b1;
        exp_push("clrerr_stk0", S_STK0, 4'b0100);
        exp_push("clrerr_cnt0", S_CNT0, 1);
        exp_push("clrerr_stk1", S_STK1, 0);
        exp_push("clrerr_cnt1", S_CNT1, 0);
        exp_push("clrerr_fv",   S_FV,   1);
        exp_push("clrerr_fch",  S_FCH,  0);
        exp_push("clrerr_fcd",  S_FCD,  4'b0100);
        exp_push("clrerr_fcy",  S_FCY,  ncyc);
        tick();
        clr = 1'b0; wf[0] = 1'b0;
        exp_push("hold_stk0", S_STK0, 4'b0100);
        exp_push("hold_cnt0", S_CNT0, 1);
        exp_push("hold_any",  S_ANY,  1);
        tick();

        clr = 1'b1;
        exp_push("clr2_stk0", S_STK0, 0);
        exp_push("clr2_any",  S_ANY,  0);
        tick();
        clr = 1'b0;

        // Simultaneous accepted write/read: at 0 -> underflow; at depth -> nothing but the flag lie.
        we = 2'b11; re = 2'b11; em = 2'b00; wf = 2'b00;
        exp_push("both_stk0", S_STK0, 4'b1010);
        exp_push("both_occ0", S_OCC0, 0);
        exp_push("both_stk1", S_STK1, 4'b0100);
        exp_push("both_occ1", S_OCC1, 4);
        exp_push("both_fch",  S_FCH,  0);
        exp_push("both_fcd",  S_FCD,  4'b1010);
        tick();
        we = 2'b00; re = 2'b00; em = 2'b01; wf = 2'b10;

        clr = 1'b1;
        exp_push("clr3_any",   S_ANY,   0);
        exp_push("clr3_sstk0", S_SSTK0, 0);
        tick();
        clr = 1'b0;

        // Read while empty: protocol error only in the strict instance.
        re = 2'b01;
        exp_push("rdempty_stk0",  S_STK0,  0);
        exp_push("rdempty_occ0",  S_OCC0,  0);
        exp_push("rdempty_sstk0", S_SSTK0, 4'b0010);
        exp_push("rdempty_socc0", S_SOCC0, 0);
        tick();
        re = 2'b00;

        em[0] = 1'b0;
        exp_push("prerst_stk0", S_STK0, 4'b1000);
        tick();
        em[0] = 1'b1;

        // Asynchronous reset mid-cycle with errors latched.
        #2;
        rst_n = 1'b0;
        #1;
        push_all_zero("arst");
        check_all();
        ncyc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        em[0] = 1'b0;
        exp_push("post_stk0", S_STK0, 4'b1000);
        exp_push("post_fv",   S_FV,   1);
        exp_push("post_fcy",  S_FCY,  0);
        exp_push("post_occ1", S_OCC1, 0);
        tick();
        em[0] = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
